// File: rtl/io_cfg_pkg.sv
// io_cfg_pkg: shared types for the I/O tile configuration sequencer.
//   state_e   - sequencer FSM states
//   FRAME_W   - configuration frame width
//   ADDR_W    - configuration bus address width
//   idx2addr  - frame bit index -> {bit-in-tile, tile index} bus address
package io_cfg_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    FIN
  } state_e;

  // address[0] selects the bit inside a tile, address[1:3] is the tile
  // index with address[1] as its MSB.
  function automatic logic [0:ADDR_W-1] idx2addr(input logic [3:0] idx);
    return {idx[0], idx[3:1]};
  endfunction

endpackage

// File: rtl/io_cfg_strobe_timer.sv
// io_cfg_strobe_timer: setup-phase timer for one bit write.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   load_i        - entering the setup phase; reload the down-counter
//   run_i         - currently in the setup phase
//   phase_done_o  - last setup cycle; the strobe follows on the next edge
module io_cfg_strobe_timer #(
  parameter int SETUP_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  output logic phase_done_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = 3'(SETUP_CYCLES);
    else if (run_i && cnt_q != '0) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Counter holds SETUP_CYCLES..1 across the setup cycles.
  assign phase_done_o = run_i && (cnt_q == 3'd1);

endmodule

// File: rtl/io_cfg_sequencer.sv
// io_cfg_sequencer: serialises 16-bit configuration frames into per-bit
// writes on the I/O tile configuration bus (setup / strobe / hold).
//   prog_clk, pReset        - clock, synchronous active-high reset
//   s_valid/s_ready/s_data  - frame handshake from the bitstream loader
//   s_parity                - even parity over s_data
//   enable/address/data_in  - tile configuration bus (all registered)
//   busy/done/error         - loader status
// Optional build macro IO_CFG_PARITY_CHECK_EN: frames with bad parity are
// rejected and set a sticky error; otherwise s_parity is ignored.
module io_cfg_sequencer
  import io_cfg_pkg::*;
#(
  parameter int NUM_TILES     = 8,
  parameter int BITS_PER_TILE = 2,
  parameter int SETUP_CYCLES  = 1
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FRAME_W-1:0] s_data,
  input  logic               s_parity,
  output logic               enable,
  output logic [0:ADDR_W-1]  address,
  output logic               data_in,
  output logic               busy,
  output logic               done,
  output logic               error
);

  // Highest index actually written; indices beyond the tile grid are skipped.
  localparam int LAST_IDX = NUM_TILES * BITS_PER_TILE - 1;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         idx_q, idx_d;
  logic               s_ready_q, s_ready_d, enable_q, enable_d;
  logic [0:ADDR_W-1]  address_q, address_d;
  logic               data_in_q, data_in_d, busy_q, busy_d;
  logic               done_q, done_d, error_q, error_d;
  logic               hs, par_ok, accept, phase_done;

  assign hs = s_valid && s_ready_q;

`ifdef IO_CFG_PARITY_CHECK_EN
  assign par_ok = ~^{s_data, s_parity};
`else
  logic unused_parity;
  assign unused_parity = s_parity;
  assign par_ok        = 1'b1;
`endif

  assign accept = hs && par_ok;

  io_cfg_strobe_timer #(.SETUP_CYCLES(SETUP_CYCLES)) u_timer (
    .clk_i        (prog_clk),
    .rst_i        (pReset),
    .load_i       (state_d == SETUP && state_q != SETUP),
    .run_i        (state_q == SETUP),
    .phase_done_o (phase_done)
  );

  // State register
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  // Next state plus frame / index datapath
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:   if (accept) begin
                frame_d = s_data;
                idx_d   = '0;
                state_d = SETUP;
              end
      SETUP:  if (phase_done) state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD:   if (idx_q == 4'(LAST_IDX)) state_d = FIN;
              else begin
                idx_d   = idx_q + 4'd1;
                state_d = SETUP;
              end
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    s_ready_d = (state_d == IDLE);
    enable_d  = (state_d == STROBE);
    busy_d    = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    done_d    = (state_d == FIN);
    address_d = address_q;
    data_in_d = data_in_q;
    // Bus address/data only move on SETUP cycles, so they stay frozen
    // through the strobe and hold of each write.
    if (state_d == SETUP) begin
      address_d = idx2addr(idx_d);
      data_in_d = frame_d[idx_d];
    end
`ifdef IO_CFG_PARITY_CHECK_EN
    error_d = error_q || (hs && !par_ok);
`else
    error_d = 1'b0;
`endif
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      s_ready_q <= 1'b0;
      enable_q  <= 1'b0;
      address_q <= '0;
      data_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      s_ready_q <= s_ready_d;
      enable_q  <= enable_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign s_ready = s_ready_q;
  assign enable  = enable_q;
  assign address = address_q;
  assign data_in = data_in_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_io_cfg_sequencer.sv
// Bench for io_cfg_sequencer: dut0 built with SETUP_CYCLES=1, dut1 with 3.
// A negedge monitor logs bus events; each test compares them with a
// cycle-level model of the frame timeline derived from the write rules.
module tb_io_cfg_sequencer;

  typedef struct packed {
    logic        d;
    logic [1:0]  kind;   // 0 accept, 1 busy change, 2 strobe, 3 done
    logic [31:0] cyc;
    logic [3:0]  addr;
    logic        dat;
  } ev_t;
  typedef ev_t evq_t[$];

  logic        clk = 1'b0;
  logic        pReset[2]   = '{1'b1, 1'b1};
  logic        s_valid[2]  = '{1'b0, 1'b0};
  logic [15:0] s_data[2]   = '{16'h0, 16'h0};
  logic        s_parity[2] = '{1'b0, 1'b0};
  logic        s_ready[2], enable[2], data_in[2], busy[2], done[2], error[2];
  logic [0:3]  address[2];

  int   cyc = 0;
  int   checks = 0, errors = 0, prot_viol = 0;
  evq_t evq, exp_q, got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_cfg_sequencer #(.SETUP_CYCLES(1)) dut0 (
    .prog_clk(clk), .pReset(pReset[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_parity(s_parity[0]), .enable(enable[0]), .address(address[0]),
    .data_in(data_in[0]), .busy(busy[0]), .done(done[0]), .error(error[0]));

  io_cfg_sequencer #(.SETUP_CYCLES(3)) dut1 (
    .prog_clk(clk), .pReset(pReset[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_parity(s_parity[1]), .enable(enable[1]), .address(address[1]),
    .data_in(data_in[1]), .busy(busy[1]), .done(done[1]), .error(error[1]));

  function automatic int sc(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic ev_t mk(input int d, input int kind, input int c, input int addr, input logic dat);
    ev_t e;
    e.d = d[0]; e.kind = kind[1:0]; e.cyc = c; e.addr = addr[3:0]; e.dat = dat;
    return e;
  endfunction

  function automatic evq_t take_log(input int d);
    evq_t r;
    foreach (evq[i]) if (evq[i].d == d[0]) r.push_back(evq[i]);
    return r;
  endfunction

  // Timeline of one accepted frame starting at handshake cycle a: each write
  // costs S+2 cycles, strobe after S setup cycles, done one cycle after the
  // last hold. Events after cycle `cut` are lost to a reset.
  function automatic void mdl_frame(input int d, input logic [15:0] f, input int a, input int cut);
    int s   = sc(d);
    int fin = a + 16 * (s + 2) + 1;
    exp_q.push_back(mk(d, 0, a, 0, 1'b0));
    exp_q.push_back(mk(d, 1, a + 1, 0, 1'b1));
    for (int k = 0; k < 16; k++) begin
      int t = a + s + 1 + (s + 2) * k;
      if (t <= cut) exp_q.push_back(mk(d, 2, t, (k % 2) * 8 + k / 2, f[k]));
    end
    if (fin <= cut) begin
      exp_q.push_back(mk(d, 1, fin, 0, 1'b0));
      exp_q.push_back(mk(d, 3, fin, 0, 1'b1));
    end
  endfunction

  // Event log and bus protocol monitor
  int         stab[2]     = '{0, 0};
  logic [4:0] prev_ad[2]  = '{5'h0, 5'h0};
  logic [4:0] hold_val[2] = '{5'h0, 5'h0};
  logic       prev_en[2]  = '{1'b0, 1'b0};
  logic       hold_chk[2] = '{1'b0, 1'b0};
  logic       busy_prev[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [4:0] ad;
      ad = {address[d], data_in[d]};
      if (s_valid[d] === 1'b1 && s_ready[d] === 1'b1) evq.push_back(mk(d, 0, cyc, 0, 1'b0));
      if (busy[d] !== busy_prev[d]) evq.push_back(mk(d, 1, cyc, 0, busy[d]));
      if (enable[d] === 1'b1) evq.push_back(mk(d, 2, cyc, address[d], data_in[d]));
      if (done[d] === 1'b1) evq.push_back(mk(d, 3, cyc, 0, 1'b1));
      busy_prev[d] <= busy[d];
      if (pReset[d]) begin
        prev_en[d] <= 1'b0; hold_chk[d] <= 1'b0; stab[d] <= 0;
      end else begin
        if (enable[d] === 1'b1 && (prev_en[d] || ad !== prev_ad[d] || stab[d] < sc(d) - 1)) begin
          prot_viol <= prot_viol + 1;
          $display("protocol violation dut%0d cycle %0d: strobe not after stable setup", d, cyc);
        end
        if (hold_chk[d] && ad !== hold_val[d]) begin
          prot_viol <= prot_viol + 1;
          $display("protocol violation dut%0d cycle %0d: bus moved in hold", d, cyc);
        end
        prev_en[d]  <= enable[d];
        hold_chk[d] <= enable[d];
        hold_val[d] <= ad;
        stab[d]     <= (ad === prev_ad[d]) ? stab[d] + 1 : 0;
      end
      prev_ad[d] <= ad;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] f, input logic p, output int a);
    int n = 0;
    while (s_ready[d] !== 1'b1 && n < 300) begin tick(1); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_ready_timeout dut%0d s_ready=%b want 1", d, s_ready[d]);
    end
    a = cyc;
    s_valid[d] = 1'b1; s_data[d] = f; s_parity[d] = p;
    tick(1);
    s_valid[d] = 1'b0; s_data[d] = 16'($urandom); s_parity[d] = 1'($urandom);
  endtask

  task automatic test_reset();
    tick(3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({s_ready[d], enable[d], address[d], data_in[d], busy[d], done[d], error[d]} !== 10'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b want 0", d,
                 {s_ready[d], enable[d], address[d], data_in[d], busy[d], done[d], error[d]});
      end
    end
    pReset[0] = 1'b0; pReset[1] = 1'b0;
    tick(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (s_ready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_first_idle_ready dut%0d got %b want 1", d, s_ready[d]);
      end
    end
  endtask

  task automatic test_single();
    int a;
    evq.delete(); exp_q.delete();
    send(0, 16'hA5C3, ^16'hA5C3, a);
    mdl_frame(0, 16'hA5C3, a, 32'h7fffffff);
    tick(56);
    got = take_log(0);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL single_evcount got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_ev%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    evq.delete(); exp_q.delete();
    while (s_ready[0] !== 1'b1) tick(1);
    a = cyc;
    s_valid[0] = 1'b1; s_data[0] = 16'hFFFF; s_parity[0] = 1'b0;
    tick(1);
    s_data[0] = 16'h0001; s_parity[0] = 1'b1;
    tick(50);                 // now in cycle a+51, second frame taken at a+50
    s_valid[0] = 1'b0;
    mdl_frame(0, 16'hFFFF, a, 32'h7fffffff);
    mdl_frame(0, 16'h0001, a + 50, 32'h7fffffff);
    tick(56);
    got = take_log(0);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_evcount got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_ev%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a, a2;
    logic [15:0] f, g;
    f = 16'($urandom); g = 16'($urandom);
    evq.delete(); exp_q.delete();
    send(0, f, ^f, a);
    while (cyc < a + 20) tick(1);
    pReset[0] = 1'b1;
    tick(1);
    pReset[0] = 1'b0;
    checks++;
    if ({s_ready[0], enable[0], busy[0], address[0], data_in[0], done[0]} !== 9'b0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 0",
               {s_ready[0], enable[0], busy[0], address[0], data_in[0], done[0]});
    end
    tick(1);
    checks++;
    if (s_ready[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_ready got %b want 1", s_ready[0]);
    end
    mdl_frame(0, f, a, a + 20);
    exp_q.push_back(mk(0, 1, a + 21, 0, 1'b0));
    send(0, g, ^g, a2);
    mdl_frame(0, g, a2, 32'h7fffffff);
    tick(56);
    got = take_log(0);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL midreset_evcount got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL midreset_ev%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_setup3();
    int a;
    evq.delete(); exp_q.delete();
    send(1, 16'h8000, 1'b1, a);
    mdl_frame(1, 16'h8000, a, 32'h7fffffff);
    tick(88);
    got = take_log(1);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL setup3_evcount got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL setup3_ev%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_parity();
    int a;
    evq.delete(); exp_q.delete();
    send(0, 16'h0001, 1'b0, a);
`ifdef IO_CFG_PARITY_CHECK_EN
    exp_q.push_back(mk(0, 0, a, 0, 1'b0));
    tick(5);
    checks++;
    if ({s_ready[0], error[0]} !== 2'b11) begin
      errors++; $display("FAIL parity_reject ready/error got %b want 11", {s_ready[0], error[0]});
    end
    send(0, 16'h0003, 1'b0, a);
    mdl_frame(0, 16'h0003, a, 32'h7fffffff);
    tick(56);
    checks++;
    if (error[0] !== 1'b1) begin
      errors++; $display("FAIL parity_sticky got %b want 1", error[0]);
    end
`else
    mdl_frame(0, 16'h0001, a, 32'h7fffffff);
    tick(56);
    checks++;
    if (error[0] !== 1'b0) begin
      errors++; $display("FAIL parity_error_tied got %b want 0", error[0]);
    end
`endif
    got = take_log(0);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL parity_evcount got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL parity_ev%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int d, a;
      logic [15:0] f;
      d = int'($urandom_range(0, 1));
      f = 16'($urandom);
      evq.delete(); exp_q.delete();
      tick(int'($urandom_range(1, 4)));
      send(d, f, ^f, a);
      mdl_frame(d, f, a, 32'h7fffffff);
      tick(16 * (sc(d) + 2) + 6);
      got = take_log(d);
      checks++;
      if (got.size() != exp_q.size()) begin
        errors++; $display("FAIL random%0d_evcount got %0d want %0d", n, got.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++; $display("FAIL random%0d_ev%0d got %h want %h", n, i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (prot_viol !== 0) begin
      errors++; $display("FAIL protocol_violations got %0d want 0", prot_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_setup3();
    test_parity();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
